cyphertext_byte_streamer: RTL and testbench

//  Downstream consumer of the AES core. Sits where cyphertext_memory sits today.

---
 rtl/cyphertext_byte_streamer_pkg.sv | 14 +
 rtl/cyphertext_byte_streamer_block_fifo.sv | 65 ++++++
 rtl/cyphertext_byte_streamer.sv | 136 +++++++++++++
 tb/tb_cyphertext_byte_streamer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cyphertext_byte_streamer_pkg.sv
// Shared constants for the cyphertext byte streamer: block/tag/beat widths,
// FIFO depth and serialiser state encodings.
package cyphertext_byte_streamer_pkg;

    localparam int CBS_TEXT_WIDTH   = 128;
    localparam int CBS_ADDR_WIDTH   = 16;
    localparam int CBS_BYTE_WIDTH   = 8;
    localparam int CBS_STREAM_DEPTH = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;

endpackage

// File: rtl/cyphertext_byte_streamer_block_fifo.sv
// Small block FIFO holding tagged cyphertext blocks; head is read combinationally
// so the serialiser can take it in the same cycle it pops.
module cyphertext_byte_streamer_block_fifo #(
    parameter int WIDTH = 144,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full_o  = (r_count == CNT_FULL);
    assign empty_o = (r_count == '0);
    assign count_o = r_count;
    assign data_o  = r_mem[r_rd_ptr];

    // A push into a full FIFO only succeeds when the head leaves in the same cycle.
    assign w_do_pop  = pop_i & ~empty_o;
    assign w_do_push = push_i & (~full_o | w_do_pop);

    always_ff @(posedge clk_i) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

endmodule

// File: rtl/cyphertext_byte_streamer.sv
// Captures each AES result on finish rising edge, queues it with its pc tag and
// streams it MSB-byte-first over an 8-bit valid/ready link.
module cyphertext_byte_streamer
    import cyphertext_byte_streamer_pkg::*;
#(
    parameter int TEXT_WIDTH = CBS_TEXT_WIDTH,
    parameter int ADDR_WIDTH = CBS_ADDR_WIDTH,
    parameter int BYTE_WIDTH = CBS_BYTE_WIDTH,
    parameter int DEPTH      = CBS_STREAM_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     finish_i,
    input  logic [ADDR_WIDTH-1:0]    pc_i,
    input  logic [TEXT_WIDTH-1:0]    cyphertext_i,
    output logic [BYTE_WIDTH-1:0]    byte_o,
    output logic                     byte_valid_o,
    input  logic                     byte_ready_i,
    output logic                     byte_last_o,
    output logic [ADDR_WIDTH-1:0]    tag_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic                     overflow_o,
    output logic                     busy_o
);

    localparam int          ENTRY_WIDTH = TEXT_WIDTH + ADDR_WIDTH;
    localparam int          BEATS       = TEXT_WIDTH / BYTE_WIDTH;
    localparam logic [3:0]  BEAT_LAST   = 4'(BEATS - 1);
    localparam logic [3:0]  BEAT_ONE    = 4'd1;

    logic                     r_finish_q;
    logic                     r_overflow;
    logic [1:0]               r_state;
    logic [TEXT_WIDTH-1:0]    r_shift;
    logic [ADDR_WIDTH-1:0]    r_tag;
    logic [3:0]               r_beat_cnt;
    logic                     r_valid;

    logic                     w_cap;
    logic                     w_pop;
    logic                     w_fire;
    logic                     w_last_beat;
    logic [ENTRY_WIDTH-1:0]   w_head;
    logic                     w_full;
    logic                     w_empty;

    assign w_cap       = finish_i & ~r_finish_q;
    assign w_fire      = r_valid & byte_ready_i;
    assign w_last_beat = (r_beat_cnt == BEAT_LAST);

    // Head leaves the FIFO when idle, or back-to-back when the final beat is taken.
    assign w_pop = ~w_empty & ((r_state == S_IDLE) ||
                               ((r_state == S_SEND) && w_fire && w_last_beat));

    cyphertext_byte_streamer_block_fifo #(
        .WIDTH (ENTRY_WIDTH),
        .DEPTH (DEPTH)
    ) u_block_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (w_cap),
        .pop_i   (w_pop),
        .data_i  ({pc_i, cyphertext_i}),
        .data_o  (w_head),
        .count_o (fifo_count_o),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_finish_q <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_finish_q <= finish_i;
            if (w_cap && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_tag      <= '0;
            r_beat_cnt <= '0;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_shift    <= w_head[TEXT_WIDTH-1:0];
                        r_tag      <= w_head[ENTRY_WIDTH-1:TEXT_WIDTH];
                        r_beat_cnt <= '0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_valid <= 1'b1;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (w_fire) begin
                        if (w_last_beat) begin
                            r_beat_cnt <= '0;
                            if (!w_empty) begin
                                r_shift <= w_head[TEXT_WIDTH-1:0];
                                r_tag   <= w_head[ENTRY_WIDTH-1:TEXT_WIDTH];
                            end else begin
                                r_shift <= {r_shift[TEXT_WIDTH-BYTE_WIDTH-1:0], {BYTE_WIDTH{1'b0}}};
                                r_valid <= 1'b0;
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_shift    <= {r_shift[TEXT_WIDTH-BYTE_WIDTH-1:0], {BYTE_WIDTH{1'b0}}};
                            r_beat_cnt <= r_beat_cnt + BEAT_ONE;
                        end
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign byte_o       = r_shift[TEXT_WIDTH-1 -: BYTE_WIDTH];
    assign byte_valid_o = r_valid;
    assign byte_last_o  = r_valid & w_last_beat;
    assign tag_o        = r_tag;
    assign overflow_o   = r_overflow;
    assign busy_o       = (r_state != S_IDLE) | ~w_empty;

endmodule

// File: tb/tb_cyphertext_byte_streamer.sv
// Directed bench for cyphertext_byte_streamer: streaming, stalls, overflow,
// level-held finish, back-to-back blocks and mid-block reset.
module tb_cyphertext_byte_streamer;

    logic          clk = 1'b0;
    logic          rst_ni;
    logic          finish_i;
    logic [15:0]   pc_i;
    logic [127:0]  cyphertext_i;
    logic [7:0]    byte_o;
    logic          byte_valid_o;
    logic          byte_ready_i;
    logic          byte_last_o;
    logic [15:0]   tag_o;
    logic [2:0]    fifo_count_o;
    logic          overflow_o;
    logic          busy_o;

    int errors = 0;
    int checks = 0;
    int watch_beats;
    logic [127:0] d3 [6];

    always #5 clk = ~clk;

    cyphertext_byte_streamer dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .finish_i     (finish_i),
        .pc_i         (pc_i),
        .cyphertext_i (cyphertext_i),
        .byte_o       (byte_o),
        .byte_valid_o (byte_valid_o),
        .byte_ready_i (byte_ready_i),
        .byte_last_o  (byte_last_o),
        .tag_o        (tag_o),
        .fifo_count_o (fifo_count_o),
        .overflow_o   (overflow_o),
        .busy_o       (busy_o)
    );

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle finish pulse; the block is pushed on the first edge it is seen high.
    task automatic capture(input logic [127:0] data, input logic [15:0] tag);
        cyphertext_i = data;
        pc_i         = tag;
        finish_i     = 1'b1;
        step();
        finish_i     = 1'b0;
        step();
    endtask

    // Receives one block; stall=1 drives ready with the repeating pattern 1,0,0,1.
    task automatic recv_block(input logic [127:0] data, input logic [15:0] tag, input bit stall);
        int beat = 0;
        int cyc  = 0;
        while (beat < 16 && cyc < 400) begin
            byte_ready_i = stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            if (byte_valid_o) begin
                check("byte", 128'(byte_o), 128'(data[127 - 8*beat -: 8]));
                check("last", 128'(byte_last_o), 128'(beat == 15));
                check("tag", 128'(tag_o), 128'(tag));
                if (byte_ready_i) beat++;
            end
            step();
            cyc++;
        end
        byte_ready_i = 1'b1;
        check("beats_received", 128'(beat), 128'(16));
    endtask

    task automatic watch(input int ncyc, input logic [127:0] data);
        for (int c = 0; c < ncyc; c++) begin
            if (byte_valid_o && byte_ready_i) begin
                if (watch_beats < 16) begin
                    check("hold_byte", 128'(byte_o), 128'(data[127 - 8*watch_beats -: 8]));
                    check("hold_last", 128'(byte_last_o), 128'(watch_beats == 15));
                end
                watch_beats++;
            end
            step();
        end
    endtask

    initial begin
        logic [127:0] d1;
        logic [127:0] da;
        logic [127:0] db;
        logic [127:0] d6a;
        logic [127:0] d6b;
        int b;
        int cyc;

        d1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        da  = 128'h000102030405060708090a0b0c0d0e0f;
        db  = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
        d6a = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
        d6b = 128'hdeadbeef0123456789abcdeffedcba98;
        for (int k = 0; k < 6; k++) begin
            d3[k] = 128'h00112233445566778899aabbccddeeff ^ {16{8'(k * 17)}};
        end

        rst_ni       = 1'b0;
        finish_i     = 1'b0;
        pc_i         = '0;
        cyphertext_i = '0;
        byte_ready_i = 1'b0;
        step();
        step();
        check("rst_valid", 128'(byte_valid_o), 128'(0));
        check("rst_byte", 128'(byte_o), 128'(0));
        check("rst_count", 128'(fifo_count_o), 128'(0));
        check("rst_busy", 128'(busy_o), 128'(0));
        rst_ni = 1'b1;
        step();

        // 1: reference AES block, ready tied high
        byte_ready_i = 1'b1;
        capture(d1, 16'h1234);
        recv_block(d1, 16'h1234, 1'b0);
        step();
        check("t1_idle_valid", 128'(byte_valid_o), 128'(0));
        check("t1_idle_busy", 128'(busy_o), 128'(0));

        // 2: same block with stalls
        capture(d1, 16'h5678);
        recv_block(d1, 16'h5678, 1'b1);
        step();

        // 3: six captures with the sink stalled
        byte_ready_i = 1'b0;
        for (int k = 0; k < 6; k++) begin
            capture(d3[k], 16'(16'h3000 + k));
        end
        check("t3_count", 128'(fifo_count_o), 128'(4));
        check("t3_overflow", 128'(overflow_o), 128'(1));
        check("t3_valid", 128'(byte_valid_o), 128'(1));
        check("t3_busy", 128'(busy_o), 128'(1));
        for (int k = 0; k < 5; k++) begin
            recv_block(d3[k], 16'(16'h3000 + k), 1'b0);
        end
        for (int c = 0; c < 5; c++) step();
        check("t3_no_sixth", 128'(byte_valid_o), 128'(0));
        check("t3_drained", 128'(fifo_count_o), 128'(0));
        check("t3_sticky", 128'(overflow_o), 128'(1));

        // 4: finish held high for 20 cycles
        byte_ready_i = 1'b1;
        cyphertext_i = d1;
        pc_i         = 16'h4444;
        finish_i     = 1'b1;
        watch_beats  = 0;
        watch(20, d1);
        finish_i = 1'b0;
        watch(30, d1);
        check("t4_beats", 128'(watch_beats), 128'(16));
        check("t4_busy", 128'(busy_o), 128'(0));

        // 5: two queued blocks stream without a bubble
        byte_ready_i = 1'b0;
        capture(da, 16'haaaa);
        capture(db, 16'hbbbb);
        byte_ready_i = 1'b1;
        for (int i = 0; i < 32; i++) begin
            check("t5_valid", 128'(byte_valid_o), 128'(1));
            check("t5_byte", 128'(byte_o),
                  128'(i < 16 ? da[127 - 8*i -: 8] : db[127 - 8*(i-16) -: 8]));
            check("t5_tag", 128'(tag_o), 128'(i < 16 ? 16'haaaa : 16'hbbbb));
            step();
        end
        check("t5_end_valid", 128'(byte_valid_o), 128'(0));

        // 6: reset at beat 7; finish held high across release
        capture(d6a, 16'h6666);
        b   = 0;
        cyc = 0;
        while (!(byte_valid_o && b == 7) && cyc < 40) begin
            if (byte_valid_o) b++;
            step();
            cyc++;
        end
        check("t6_at_beat7", 128'(b), 128'(7));
        check("t6_beat7_byte", 128'(byte_o), 128'(d6a[127 - 56 -: 8]));
        #2;
        rst_ni = 1'b0;
        #1;
        check("t6_async_valid", 128'(byte_valid_o), 128'(0));
        check("t6_async_byte", 128'(byte_o), 128'(0));
        check("t6_async_tag", 128'(tag_o), 128'(0));
        check("t6_async_overflow", 128'(overflow_o), 128'(0));
        check("t6_async_busy", 128'(busy_o), 128'(0));
        cyphertext_i = d6b;
        pc_i         = 16'h6767;
        finish_i     = 1'b1;
        step();
        step();
        check("t6_no_cap_in_reset", 128'(fifo_count_o), 128'(0));
        rst_ni = 1'b1;
        step();
        check("t6_cap_on_release", 128'(fifo_count_o), 128'(1));
        recv_block(d6b, 16'h6767, 1'b0);
        finish_i = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check("t6_final_busy", 128'(busy_o), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
